// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [3:0] ADD3     = 4'd3;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the value source and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Add-3 correction for one BCD digit ahead of a double-dabble shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    always_comb begin
        adjusted = (digit >= 4'd5) ? (digit + ADD3) : digit;
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, result held between runs.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 8
) (
    input logic             clk,
    input logic             rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned     BCD_W    = 4 * DIGITS;
    localparam int unsigned     CNT_W    = $clog2(BIN_W + 1);
    localparam logic [63:0]     LIMIT    = pow10(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  scr_q, scr_d, scr_adj;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_nxt_q, ovf_nxt_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              busy;
    logic              done;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scr_q[4*g +: 4]),
            .adjusted (scr_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        bcd_d     = bcd_q;
        ovf_nxt_d = ovf_nxt_q;
        ovf_d     = ovf_q;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = bus.start;
            end
            StShift: begin
                busy  = 1'b1;
                // Carry out of the top digit is dropped; it only occurs on overflow.
                scr_d = BCD_W'({scr_adj, bin_q[BIN_W-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                bcd_d   = ovf_nxt_q ? {DIGITS{BCD_NINE}} : scr_q;
                ovf_d   = ovf_nxt_q;
                state_d = StIdle;
                accept  = bus.start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d   = StShift;
            bin_d     = bus.bin;
            scr_d     = '0;
            cnt_d     = CNT_LOAD;
            ovf_nxt_d = (64'(bus.bin) >= LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bin_q     <= '0;
            scr_q     <= '0;
            bcd_q     <= '0;
            ovf_nxt_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            bcd_q     <= bcd_d;
            ovf_nxt_q <= ovf_nxt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: directed table, multi-cycle corner sequences, random vs. decimal model.
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W  = 32;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned LAT    = BIN_W + 1;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] bin;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    // Decimal reference: plain div/mod, saturating at 10**DIGITS.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [31:0] r;
        x = longint'(v);
        if (x >= 64'd100000000) return 32'h99999999;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v);
        return longint'(v) >= 64'd100000000;
    endfunction

    // Idle DUT assumed; inputs driven on negedge, outputs sampled on negedge.
    task automatic do_conv(input string name, input logic [31:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int cyc;
        int busy_cnt;
        logic stable;
        logic [31:0] held;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        held      = bus.bcd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = $urandom;
        cyc = 1;
        busy_cnt = 0;
        stable = 1'b1;
        while (!bus.done && cyc < LAT + 8) begin
            if (bus.busy) busy_cnt++;
            if (bus.bcd !== held) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(LAT));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(BIN_W));
        chk({name, "_bcd_held"}, 64'(stable), 64'd1);
        chk({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({name, "_bcd"}, 64'(bus.bcd), 64'(exp_bcd));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        chk({name, "_done_after"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        int first;
        logic stable;
        logic [31:0] r;

        vecs[0] = '{32'd0,         32'h00000000, 1'b0};
        vecs[1] = '{32'd12345678,  32'h12345678, 1'b0};
        vecs[2] = '{32'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{32'd100000000, 32'h99999999, 1'b1};
        vecs[4] = '{32'hFFFFFFFF,  32'h99999999, 1'b1};
        vecs[5] = '{32'd7,         32'h00000007, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_bcd",  64'(bus.bcd),  64'd0);
        chk("reset_ovf",  64'(bus.ovf),  64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf);
        end

        // A second start while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd42;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        first  = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin
                bus.start = 1'b1;
                bus.bin   = 32'd99;
            end else if (c == 11) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
        chk("ignored_start_pulses",  64'(pulses), 64'd1);
        chk("ignored_start_latency", 64'(first),  64'(LAT));
        chk("ignored_start_bcd",     64'(bus.bcd), 64'h42);

        // Start held high: back-to-back runs, second bin captured in the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.bin = 32'd10;
        cyc = 1;
        while (!bus.done && cyc < LAT + 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", 64'(cyc), 64'(LAT));
        @(negedge clk);
        chk("b2b_first_bcd",  64'(bus.bcd),  64'h5);
        chk("b2b_rebusy",     64'(bus.busy), 64'd1);
        cyc = 1;
        stable = 1'b1;
        while (!bus.done && cyc < LAT + 8) begin
            if (bus.bcd !== 32'h5) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("b2b_second_latency", 64'(cyc),    64'(LAT));
        chk("b2b_bcd_stable",     64'(stable), 64'd1);
        @(negedge clk);
        chk("b2b_second_bcd", 64'(bus.bcd),  64'h10);
        chk("b2b_idle",       64'(bus.busy), 64'd0);

        // Reset mid-conversion discards the run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd12345678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_bcd",  64'(bus.bcd),  64'd0);
        chk("midrst_ovf",  64'(bus.ovf),  64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done || bus.busy) pulses++;
            @(negedge clk);
        end
        chk("midrst_quiet", 64'(pulses), 64'd0);
        do_conv("midrst_fresh", 32'd12345678, 32'h12345678, 1'b0);

        for (int i = 0; i < 20; i++) begin
            r = (i % 3 == 0) ? 32'($urandom_range(0, 200_000_000)) : $urandom;
            if (i % 4 == 1) r = 32'($urandom_range(0, 9999));
            do_conv($sformatf("rand%0d", i), r, ref_bcd(r), ref_ovf(r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
